mio_data_responder: RTL and testbench

Memory/IO responder on the CPU data-bus side: accepts one load or store per request from the CPU, services it after a parameterised number of wait states, and pulses `MIO_ready` with the read data. It owns:
- a word-addressed data RAM;
- an LED output register;
- a free-running cycle counter.

It sits between the CPU core's data port and the board I/O.

---
 rtl/mio_data_responder_pkg.sv | 23 ++
 rtl/mio_ram.sv | 29 ++
 rtl/mio_data_responder.sv | 153 +++++++++++++++
 tb/tb_mio_data_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_data_responder_pkg.sv
// Shared definitions for the CPU data-side memory/IO responder: address map,
// FSM encoding, wait-counter width and the latched request payload.
package mio_data_responder_pkg;

  localparam int unsigned MIO_DATA_W = 32;
  localparam int unsigned MIO_WAIT_W = 4;

  localparam logic [MIO_DATA_W-1:0] MIO_LED_ADDR = 32'hE000_0000;
  localparam logic [MIO_DATA_W-1:0] MIO_CNT_ADDR = 32'hF000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mio_state_e;

  typedef struct packed {
    logic                  we;
    logic [MIO_DATA_W-1:0] addr;
    logic [MIO_DATA_W-1:0] wdata;
  } mio_req_t;

endpackage

// File: rtl/mio_ram.sv
// Single-port word RAM: synchronous write, registered read, one access per enable.
module mio_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents survive reset; the read register only moves on a load.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mio_data_responder.sv
// Data-bus responder: accepts one CPU load/store, waits WAIT_CYCLES, commits it
// to RAM / LED / cycle counter and returns a one-cycle MIO_ready pulse.
module mio_data_responder
  import mio_data_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CPU_MIO,
  input  logic                  MemRW,
  input  logic [MIO_DATA_W-1:0] Addr_in,
  input  logic [MIO_DATA_W-1:0] Data_write,
  output logic [MIO_DATA_W-1:0] Data_read,
  output logic                  MIO_ready,
  output logic                  bus_err,
  output logic [MIO_DATA_W-1:0] led_out
);

  localparam logic [MIO_WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : MIO_WAIT_W'(WAIT_CYCLES - 1);

  mio_state_e            state_q, state_d;
  mio_req_t              req_q, req_c;
  logic [MIO_WAIT_W-1:0] wcnt_q;
  logic [MIO_DATA_W-1:0] cnt_q;
  logic [MIO_DATA_W-1:0] led_q;
  logic [MIO_DATA_W-1:0] rd_q;
  logic [MIO_DATA_W-1:0] ram_q;
  logic                  ram_rd_q;
  logic                  ready_q;
  logic                  err_q;

  logic                  commit_c;
  logic                  accept_c;
  logic                  is_ram, is_led, is_cnt, aligned;
  logic                  fault_c;
  logic                  ram_en_c;
  logic [MIO_DATA_W-1:0] rd_c;

  // With zero wait states the commit happens on the acceptance edge, so the
  // live bus inputs stand in for the not-yet-latched request.
  always_comb begin
    req_c = req_q;
    if (state_q == ST_IDLE) begin
      req_c.we    = MemRW;
      req_c.addr  = Addr_in;
      req_c.wdata = Data_write;
    end
  end

  always_comb begin
    state_d  = state_q;
    commit_c = 1'b0;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (CPU_MIO) begin
          accept_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            commit_c = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address decode and fault classification of the request being committed.
  always_comb begin
    is_ram   = (req_c.addr[MIO_DATA_W-1:ADDR_WIDTH+2] == '0);
    is_led   = (req_c.addr == MIO_LED_ADDR);
    is_cnt   = (req_c.addr == MIO_CNT_ADDR);
    aligned  = (req_c.addr[1:0] == 2'b00);
    fault_c  = !aligned || !(is_ram || is_led || (is_cnt && !req_c.we));
    ram_en_c = commit_c && !rst && aligned && is_ram;
    rd_c     = '0;
    if (!fault_c && !req_c.we) begin
      if (is_led) begin
        rd_c = led_q;
      end else if (is_cnt) begin
        rd_c = cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      wcnt_q   <= '0;
      cnt_q    <= '0;
      led_q    <= '0;
      rd_q     <= '0;
      ram_rd_q <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + 32'd1;
      ready_q <= commit_c;
      err_q   <= commit_c && fault_c;
      if (accept_c) begin
        req_q  <= req_c;
        wcnt_q <= WAIT_INIT;
      end else if (state_q == ST_WAIT) begin
        wcnt_q <= wcnt_q - MIO_WAIT_W'(1);
      end
      if (commit_c) begin
        rd_q     <= rd_c;
        ram_rd_q <= !fault_c && is_ram && !req_c.we;
        if (!fault_c && is_led && req_c.we) begin
          led_q <= req_c.wdata;
        end
      end
    end
  end

  mio_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (MIO_DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en_c),
    .we    (req_c.we),
    .addr  (req_c.addr[ADDR_WIDTH+1:2]),
    .wdata (req_c.wdata),
    .rdata (ram_q)
  );

  assign MIO_ready = ready_q;
  assign bus_err   = err_q;
  assign led_out   = led_q;
  assign Data_read = ready_q ? (ram_rd_q ? ram_q : rd_q) : '0;

endmodule

// File: tb/tb_mio_data_responder.sv
// Randomized self-checking bench: two responders (2 and 0 wait states) driven
// against an address-map level reference model.
module tb_mio_data_responder;

  localparam int unsigned AW = 8;
  localparam int W_OF [2] = '{2, 0};
  localparam logic [31:0] LED_A = 32'hE000_0000;
  localparam logic [31:0] CNT_A = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_mio    [2];
  logic        memrw      [2];
  logic [31:0] addr_in    [2];
  logic [31:0] data_write [2];
  logic [31:0] data_read  [2];
  logic        mio_ready  [2];
  logic        bus_err    [2];
  logic [31:0] led_out    [2];

  int n_vec = 0;
  int n_err = 0;
  int edge_no = 0;

  logic [31:0] mem_m [2][256];
  logic [31:0] led_m [2];
  logic [31:0] cbase_val [2];
  int          cbase_edge [2];

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  mio_data_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio[0]), .MemRW(memrw[0]),
    .Addr_in(addr_in[0]), .Data_write(data_write[0]), .Data_read(data_read[0]),
    .MIO_ready(mio_ready[0]), .bus_err(bus_err[0]), .led_out(led_out[0])
  );

  mio_data_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio[1]), .MemRW(memrw[1]),
    .Addr_in(addr_in[1]), .Data_write(data_write[1]), .Data_read(data_read[1]),
    .MIO_ready(mio_ready[1]), .bus_err(bus_err[1]), .led_out(led_out[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one committed access at a given commit edge.
  task automatic model(input int d, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input int commit_edge,
                       output logic [31:0] ed, output bit ee);
    bit in_ram, in_led, in_cnt;
    in_ram = (a < 32'h0000_0400);
    in_led = (a == LED_A);
    in_cnt = (a == CNT_A);
    ee = (a[1:0] != 2'b00) || !(in_ram || in_led || (in_cnt && !we));
    ed = 32'h0;
    if (!ee) begin
      if (we) begin
        if (in_ram) mem_m[d][a[9:2]] = wd;
        else if (in_led) led_m[d] = wd;
      end else begin
        if (in_ram) ed = mem_m[d][a[9:2]];
        else if (in_led) ed = led_m[d];
        else ed = cbase_val[d] + 32'(commit_edge - 1 - cbase_edge[d]);
      end
    end
  endtask

  task automatic access(input int d, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] got);
    int lat;
    int acc;
    logic [31:0] ed;
    bit ee;
    @(negedge clk);
    cpu_mio[d] = 1'b1;
    memrw[d] = we;
    addr_in[d] = a;
    data_write[d] = wd;
    acc = edge_no + 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mio_ready[d] && lat < 40);
    cpu_mio[d] = 1'b0;
    memrw[d] = $urandom_range(0, 1);
    addr_in[d] = $urandom;
    model(d, we, a, wd, acc + W_OF[d], ed, ee);
    chk("latency", 32'(lat), 32'(W_OF[d] + 1));
    chk("rdata", data_read[d], ed);
    chk("bus_err", {31'b0, bus_err[d]}, {31'b0, ee});
    chk("led_out", led_out[d], led_m[d]);
    got = data_read[d];
  endtask

  task automatic release_reset();
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cbase_edge[d] = edge_no;
      cbase_val[d] = 32'h0;
      led_m[d] = 32'h0;
    end
  endtask

  function automatic logic [31:0] pool_addr();
    int w;
    w = $urandom_range(0, 16);
    if (w == 16) w = 255;
    return 32'(w) << 2;
  endfunction

  initial begin
    logic [31:0] got;
    logic [31:0] prior;
    logic [31:0] a;
    logic [31:0] ed;
    bit ee;
    int gap;
    for (int d = 0; d < 2; d++) begin
      cpu_mio[d] = 1'b0;
      memrw[d] = 1'b0;
      addr_in[d] = 32'h0;
      data_write[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    release_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, mio_ready[d]}, 32'h0);
      chk("rst_err", {31'b0, bus_err[d]}, 32'h0);
      chk("rst_rdata", data_read[d], 32'h0);
      chk("rst_led", led_out[d], 32'h0);
    end

    // Give every RAM word the bench touches a known value.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 17; w++) begin
        access(d, 1'b1, (w == 16) ? 32'h0000_03FC : 32'(w) << 2, $urandom, got);
      end
    end

    access(0, 1'b1, 32'h0000_0010, 32'h1234_5678, got);
    access(0, 1'b0, 32'h0000_0010, 32'h0, got);
    chk("ram_roundtrip", got, 32'h1234_5678);
    access(0, 1'b1, LED_A, 32'h0000_00A5, got);
    chk("led_store", led_out[0], 32'h0000_00A5);
    access(0, 1'b0, LED_A, 32'h0, got);
    chk("led_load", got, 32'h0000_00A5);

    access(0, 1'b0, CNT_A, 32'h0, prior);
    access(0, 1'b0, CNT_A, 32'h0, got);
    chk("cnt_spacing", got - prior, 32'd4);

    access(0, 1'b0, 32'h0000_0012, 32'h0, got);
    access(0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, got);
    access(0, 1'b1, CNT_A, 32'h0000_0000, got);
    access(0, 1'b0, 32'h0000_0010, 32'h0, got);
    chk("ram_after_faults", got, 32'h1234_5678);

    @(negedge clk);
    force u_dut_w2.cnt_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release u_dut_w2.cnt_q;
    cbase_edge[0] = edge_no;
    cbase_val[0] = 32'hFFFF_FFFD;
    access(0, 1'b0, CNT_A, 32'h0, got);
    chk("cnt_wrap", got, 32'h0);

    for (int i = 0; i < 80; i++) begin
      int d;
      int kind;
      bit we;
      d = $urandom_range(0, 1);
      kind = $urandom_range(0, 7);
      we = $urandom_range(0, 1);
      case (kind)
        0, 1, 2: a = pool_addr();
        3:       a = LED_A;
        4:       begin a = CNT_A; we = 1'b0; end
        5:       begin a = CNT_A; we = 1'b1; end
        6:       a = pool_addr() | 32'($urandom_range(1, 3));
        default: a = ($urandom_range(0, 1) == 1) ? 32'h0000_0400 :
                     (32'h4000_0000 | ($urandom & 32'h0FFF_FFFC));
      endcase
      access(d, we, a, $urandom, got);
    end

    // Zero wait states with the request held: one response every second cycle.
    @(negedge clk);
    cpu_mio[1] = 1'b1;
    memrw[1] = 1'b0;
    addr_in[1] = 32'h0;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!mio_ready[1] && gap < 10);
      chk("b2b_gap", 32'(gap), (k == 0) ? 32'd1 : 32'd2);
      model(1, 1'b0, addr_in[1], 32'h0, 0, ed, ee);
      chk("b2b_rdata", data_read[1], ed);
      addr_in[1] = 32'(k + 1) << 2;
    end
    cpu_mio[1] = 1'b0;

    // Reset during WAIT abandons the store.
    prior = mem_m[0][8];
    @(negedge clk);
    cpu_mio[0] = 1'b1;
    memrw[0] = 1'b1;
    addr_in[0] = 32'h0000_0020;
    data_write[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1'b1;
    cpu_mio[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_wait_noready", {31'b0, mio_ready[0]}, 32'h0);
    end
    release_reset();
    access(0, 1'b0, 32'h0000_0020, 32'h0, got);
    chk("rst_wait_nowrite", got, prior);
    chk("rst_wait_led", led_out[0], 32'h0);
    access(1, 1'b0, CNT_A, 32'h0, got);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
